// File: rtl/frame_pkg.sv
// Shared types and default geometry for the frame-capture block.
package frame_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int V_ACTIVE_DEF = 480;
   localparam int ADDR_W_DEF   = 19;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_CAPTURE,
      ST_DONE
   } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Registered rise/fall detector for a clk-synchronous level.
// No edge is reported on the first cycle after reset.
module sync_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic sig,
   output logic rise,
   output logic fall
);

   logic sig_p0;
   logic primed_p0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_p0    <= 1'b0;
         primed_p0 <= 1'b0;
      end else begin
         sig_p0    <= sig;
         primed_p0 <= 1'b1;
      end
   end

   // primed_p0 masks the stale comparison against the reset value of sig_p0
   assign rise = primed_p0 &  sig & ~sig_p0;
   assign fall = primed_p0 & ~sig &  sig_p0;

endmodule

// File: rtl/frame_capture.sv
// Camera-to-frame-buffer capture: keeps the luma byte of each YUV pixel pair.
// Optional sticky line/frame error flags are built when FRAME_CAPTURE_ERR_EN is defined.
module frame_capture
   import frame_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int ADDR_W   = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              capture_en,
   input  logic              vsync_in,
   input  logic              href_in,
   input  logic              pix_valid,
   input  logic [7:0]        pix_data,
   input  logic              err_clr,
   output logic              bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [7:0]        bram_din,
   output logic              frame_done,
   output logic              frame_ready,
   output logic [7:0]        frame_cnt,
   output logic              line_err,
   output logic              frame_err
);

   localparam int COL_W = $clog2(H_ACTIVE + 2);
   localparam int ROW_W = $clog2(V_ACTIVE + 2);
   localparam logic [COL_W-1:0]  COL_END   = COL_W'(H_ACTIVE);
   localparam logic [COL_W-1:0]  COL_SAT   = COL_W'(H_ACTIVE + 1);
   localparam logic [ROW_W-1:0]  ROW_END   = ROW_W'(V_ACTIVE);
   localparam logic [ROW_W-1:0]  ROW_SAT   = ROW_W'(V_ACTIVE + 1);
   localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);

   logic vs_rise, vs_fall, hr_rise, hr_fall;

   sync_edge_det u_vs_edge (
      .clk  (clk),
      .rst_n(rst_n),
      .sig  (vsync_in),
      .rise (vs_rise),
      .fall (vs_fall)
   );

   sync_edge_det u_hr_edge (
      .clk  (clk),
      .rst_n(rst_n),
      .sig  (href_in),
      .rise (hr_rise),
      .fall (hr_fall)
   );

   state_t state, state_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:    if (vs_rise)                state_nx = ST_ARMED;
         ST_ARMED:   if (vs_fall && capture_en)  state_nx = ST_CAPTURE;
         ST_CAPTURE: if (vs_rise)                state_nx = ST_DONE;
         ST_DONE:                                state_nx = ST_ARMED;
         default:                                state_nx = ST_IDLE;
      endcase
   end

   logic              phase;
   logic [COL_W-1:0]  col;
   logic [ROW_W-1:0]  row;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] row_base;

   logic in_cap, start_cap, beat, phase_eff, keep, in_window, line_end, frame_end;

   assign in_cap    = (state == ST_CAPTURE);
   assign start_cap = (state == ST_ARMED) && vs_fall && capture_en;
   assign beat      = in_cap && href_in && pix_valid;
   assign phase_eff = hr_rise ? 1'b0 : phase;
   assign keep      = beat && !phase_eff;
   assign in_window = (col < COL_END) && (row < ROW_END);
   assign line_end  = in_cap && hr_fall;
   assign frame_end = in_cap && vs_rise;

   // Stage p0: column/row/address tracking; col and row saturate one past
   // the active area so overlong lines and frames stay distinguishable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase    <= 1'b0;
         col      <= '0;
         row      <= '0;
         addr     <= '0;
         row_base <= '0;
      end else if (start_cap) begin
         phase    <= 1'b0;
         col      <= '0;
         row      <= '0;
         addr     <= '0;
         row_base <= '0;
      end else if (in_cap) begin
         phase <= beat ? ~phase_eff : phase_eff;
         if (line_end) begin
            col <= '0;
            if (row != ROW_SAT) row <= row + ROW_W'(1);
            if (row < ROW_END) begin
               row_base <= row_base + LINE_STEP;
               addr     <= row_base + LINE_STEP;
            end
         end else if (keep) begin
            if (col != COL_SAT) col <= col + COL_W'(1);
            if (in_window)      addr <= addr + ADDR_W'(1);
         end
      end
   end

   // Stage p1: frame-buffer write port, one cycle behind the kept byte
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bram_we   <= 1'b0;
         bram_addr <= '0;
         bram_din  <= '0;
      end else begin
         bram_we <= keep && in_window;
         if (keep && in_window) begin
            bram_addr <= addr;
            bram_din  <= pix_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_done  <= 1'b0;
         frame_ready <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         frame_done <= frame_end;
         if (frame_end) begin
            frame_ready <= 1'b1;
            frame_cnt   <= frame_cnt + 8'd1;
         end
      end
   end

`ifdef FRAME_CAPTURE_ERR_EN
   // A new error in the same cycle as err_clr wins over the clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_err  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (line_end && (col != COL_END))   line_err <= 1'b1;
         else if (err_clr)                   line_err <= 1'b0;
         if (frame_end && (row != ROW_END))  frame_err <= 1'b1;
         else if (err_clr)                   frame_err <= 1'b0;
      end
   end
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign line_err       = 1'b0;
   assign frame_err      = 1'b0;
`endif

endmodule

// File: tb/tb_frame_capture.sv
// Bench for frame_capture on a reduced 8x4 geometry; error expectations
// follow whether FRAME_CAPTURE_ERR_EN is defined.
module tb_frame_capture;

   localparam int H  = 8;
   localparam int V  = 4;
   localparam int AW = 6;
`ifdef FRAME_CAPTURE_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          capture_en = 1'b1;
   logic          vsync_in = 1'b1;
   logic          href_in = 1'b0;
   logic          pix_valid = 1'b0;
   logic [7:0]    pix_data = 8'h00;
   logic          err_clr = 1'b0;
   logic          bram_we;
   logic [AW-1:0] bram_addr;
   logic [7:0]    bram_din;
   logic          frame_done, frame_ready, line_err, frame_err;
   logic [7:0]    frame_cnt;

   frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .capture_en(capture_en), .vsync_in(vsync_in),
      .href_in(href_in), .pix_valid(pix_valid), .pix_data(pix_data),
      .err_clr(err_clr), .bram_we(bram_we), .bram_addr(bram_addr),
      .bram_din(bram_din), .frame_done(frame_done), .frame_ready(frame_ready),
      .frame_cnt(frame_cnt), .line_err(line_err), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Behavioural model: 0 idle, 1 armed, 2 capturing
   int m_mode = 0;
   bit m_vs = 1'b1;
   int m_row = 0;
   int m_cnt = 0;
   bit m_ready = 1'b0;
   bit m_lerr = 1'b0;
   bit m_ferr = 1'b0;
   int done_pending = 0;
   int exp_addr[$];
   int exp_data[$];
   int line_seed = 3;

   int wr_count = 0;
   int last_addr = -1;
   int first_addr = -1;
   bit want_first = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, #1 after the active edge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (bram_we) begin
            chk("write_expected", int'(exp_addr.size() > 0), 1);
            if (exp_addr.size() > 0) begin
               chk("bram_addr", int'(bram_addr), exp_addr.pop_front());
               chk("bram_din", int'(bram_din), exp_data.pop_front());
            end
            wr_count++;
            last_addr = int'(bram_addr);
            if (want_first) begin
               first_addr = int'(bram_addr);
               want_first = 1'b0;
            end
         end
         chk("frame_done", int'(frame_done), done_pending);
         done_pending = 0;
         chk("frame_cnt", int'(frame_cnt), m_cnt);
         chk("frame_ready", int'(frame_ready), int'(m_ready));
         chk("line_err", int'(line_err), int'(m_lerr));
         chk("frame_err", int'(frame_err), int'(m_ferr));
      end
   end

   task automatic drive_vsync(input bit v);
      @(negedge clk);
      if (v && !m_vs) begin
         if (m_mode == 2) begin
            done_pending = 1;
            m_cnt = (m_cnt + 1) % 256;
            m_ready = 1'b1;
            if (ERR_EN && m_row != V) m_ferr = 1'b1;
            m_mode = 1;
         end else if (m_mode == 0) begin
            m_mode = 1;
         end
      end else if (!v && m_vs) begin
         if (m_mode == 1 && capture_en) begin
            m_mode = 2;
            m_row = 0;
         end
      end
      m_vs = v;
      vsync_in = v;
   endtask

   task automatic vsync_pulse();
      drive_vsync(1'b1);
      repeat (3) @(negedge clk);
      drive_vsync(1'b0);
      repeat (2) @(negedge clk);
      chk("done_pending_cleared", done_pending, 0);
      chk("writes_drained", exp_addr.size(), 0);
   endtask

   task automatic send_line(input int n, input bit gaps, input bit clr_at_end);
      int seed;
      seed = line_seed;
      line_seed = line_seed + 29;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         href_in = 1'b1;
         pix_valid = 1'b1;
         pix_data = 8'((seed + k * 7) & 255);
         if (m_mode == 2 && k % 2 == 0 && k / 2 < H && m_row < V) begin
            exp_addr.push_back(m_row * H + k / 2);
            exp_data.push_back((seed + k * 7) & 255);
         end
         if (gaps) begin
            @(negedge clk);
            pix_valid = 1'b0;
         end
      end
      @(negedge clk);
      href_in = 1'b0;
      pix_valid = 1'b0;
      err_clr = clr_at_end;
      if (clr_at_end) begin
         m_lerr = 1'b0;
         m_ferr = 1'b0;
      end
      if (m_mode == 2) begin
         if (ERR_EN && (n + 1) / 2 != H) m_lerr = 1'b1;
         m_row++;
      end
      @(negedge clk);
      err_clr = 1'b0;
      pix_valid = 1'b1;          // byte outside href: must be ignored
      pix_data = 8'hEE;
      @(negedge clk);
      pix_valid = 1'b0;
   endtask

   task automatic clear_err();
      @(negedge clk);
      err_clr = 1'b1;
      m_lerr = 1'b0;
      m_ferr = 1'b0;
      @(negedge clk);
      err_clr = 1'b0;
   endtask

   task automatic full_frame();
      for (int l = 0; l < V; l++) send_line(2 * H, 1'b0, 1'b0);
      vsync_pulse();
   endtask

   task automatic do_reset(input bit vs_level);
      @(negedge clk);
      rst_n = 1'b0;
      vsync_in = vs_level;
      href_in = 1'b0;
      pix_valid = 1'b0;
      err_clr = 1'b0;
      m_mode = 0;
      m_cnt = 0;
      m_ready = 1'b0;
      m_lerr = 1'b0;
      m_ferr = 1'b0;
      done_pending = 0;
      exp_addr.delete();
      exp_data.delete();
      m_vs = vs_level;
      #1;
      chk("rst_bram_we", int'(bram_we), 0);
      chk("rst_bram_addr", int'(bram_addr), 0);
      chk("rst_bram_din", int'(bram_din), 0);
      chk("rst_frame_done", int'(frame_done), 0);
      chk("rst_frame_ready", int'(frame_ready), 0);
      chk("rst_frame_cnt", int'(frame_cnt), 0);
      chk("rst_line_err", int'(line_err), 0);
      chk("rst_frame_err", int'(frame_err), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Release with vsync already high: no rising edge may be seen
      do_reset(1'b1);
      repeat (3) @(negedge clk);
      drive_vsync(1'b0);
      repeat (3) @(negedge clk);

      // First full frame
      vsync_pulse();
      wr_count = 0;
      full_frame();
      chk("f1_writes", wr_count, V * H);
      chk("f1_last_addr", last_addr, V * H - 1);
      chk("f1_frame_cnt", int'(frame_cnt), 1);
      chk("f1_frame_ready", int'(frame_ready), 1);

      // Overlong first line (18 bytes) and a gapped line
      wr_count = 0;
      send_line(2 * H + 2, 1'b0, 1'b0);
      send_line(2 * H, 1'b0, 1'b0);
      send_line(2 * H, 1'b1, 1'b0);
      send_line(2 * H, 1'b0, 1'b0);
      vsync_pulse();
      chk("long_writes", wr_count, V * H);
      chk("long_line_err", int'(line_err), int'(ERR_EN));
      clear_err();
      @(negedge clk);
      chk("long_err_cleared", int'(line_err), 0);

      // Short frame of 3 lines, first with an odd byte count
      send_line(2 * H + 1, 1'b0, 1'b0);
      send_line(2 * H, 1'b0, 1'b0);
      send_line(2 * H, 1'b0, 1'b0);
      vsync_pulse();
      chk("short_frame_cnt", int'(frame_cnt), 3);
      chk("short_frame_err", int'(frame_err), int'(ERR_EN));
      clear_err();
      @(negedge clk);
      chk("short_err_cleared", int'(frame_err), 0);

      // Error set coincides with err_clr: set wins
      send_line(2 * H - 2, 1'b0, 1'b1);
      chk("set_over_clr", int'(line_err), int'(ERR_EN));
      for (int l = 1; l < V; l++) send_line(2 * H, 1'b0, 1'b0);
      capture_en = 1'b0;
      vsync_pulse();
      clear_err();

      // Frame while capture disabled at the vsync fall: nothing written
      wr_count = 0;
      for (int l = 0; l < V; l++) send_line(2 * H, 1'b0, 1'b0);
      chk("disabled_writes", wr_count, 0);
      capture_en = 1'b1;
      vsync_pulse();
      chk("disabled_frame_cnt", int'(frame_cnt), 4);
      wr_count = 0;
      full_frame();
      chk("resumed_writes", wr_count, V * H);
      chk("resumed_frame_cnt", int'(frame_cnt), 5);

      // Reset in the middle of a frame
      send_line(2 * H, 1'b0, 1'b0);
      send_line(2 * H, 1'b0, 1'b0);
      do_reset(1'b0);
      send_line(2 * H, 1'b0, 1'b0);
      send_line(2 * H, 1'b0, 1'b0);
      vsync_pulse();
      wr_count = 0;
      want_first = 1'b1;
      full_frame();
      chk("post_reset_first_addr", first_addr, 0);
      chk("post_reset_writes", wr_count, V * H);
      chk("post_reset_frame_cnt", int'(frame_cnt), 1);

      // 256 more frames: counter wraps, ready stays set
      for (int f = 0; f < 256; f++) begin
         full_frame();
         if (f == 254) begin
            chk("wrap_frame_cnt_zero", int'(frame_cnt), 0);
            chk("wrap_frame_ready", int'(frame_ready), 1);
         end
      end
      chk("wrap_frame_cnt_final", int'(frame_cnt), 1);
      chk("wrap_ready_final", int'(frame_ready), 1);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/frame_capture.md
FRAME_CAPTURE -- requirements
Module: frame_capture

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, active lines per frame.
REQ-003 SHALL have parameter ADDR_W, default 19, frame-buffer address width; its write address is row*H_ACTIVE+col.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port capture_en  input  1  permits starting a new frame.
REQ-007 SHALL have port vsync_in  input  1  camera vsync, clk-synchronous; high means vertical blanking.
REQ-008 SHALL have port href_in  input  1  camera href, clk-synchronous; high means active line.
REQ-009 SHALL have port pix_valid  input  1  one camera byte is on pix_data this cycle.
REQ-010 SHALL have port pix_data  input  8  camera byte stream, two bytes per pixel, Y first.
REQ-011 SHALL have port bram_we  output  1  frame-buffer write strobe.
REQ-012 SHALL have port bram_addr  output  ADDR_W  frame-buffer write address.
REQ-013 SHALL have port bram_din  output  8  frame-buffer write data (luma).
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse when a frame completes.
REQ-015 SHALL have port frame_ready  output  1  sticky level; high once the first full frame is stored.
REQ-016 SHALL have port frame_cnt  output  8  completed-frame count, wraps 255->0.
REQ-017 SHALL have ports err_clr (input 1), line_err (output 1) and frame_err (output 1), used per REQ-030.

Function
REQ-018 SHALL implement states IDLE, ARMED, CAPTURE and DONE.
REQ-019 SHALL detect vsync_in and href_in edges from a one-cycle registered copy of each; the first cycle after reset SHALL NOT produce an edge.
REQ-020 SHALL move IDLE->ARMED on a vsync_in rising edge, and ARMED->CAPTURE on a vsync_in falling edge only when capture_en=1; with capture_en=0 it SHALL remain in ARMED.
REQ-021 SHALL, in CAPTURE, clear the byte phase on each href_in rising edge, toggle the phase on each pix_valid with href_in=1, keep phase-0 bytes (Y) and drop phase-1 bytes.
REQ-022 SHALL write each kept byte with 1-cycle latency: bram_we=1 for one cycle, bram_din=byte, bram_addr=row*H_ACTIVE+col; the address SHALL come from an incrementing counter, with no multiplier.
REQ-023 SHALL suppress writes for col>=H_ACTIVE or row>=V_ACTIVE; the counters SHALL saturate and never wrap into valid addresses.
REQ-024 SHALL, on an href_in falling edge in CAPTURE, set col=0, increment row, and realign the address counter to row*H_ACTIVE.
REQ-025 SHALL, on a vsync_in rising edge in CAPTURE, enter DONE; in DONE it SHALL pulse frame_done, set frame_ready, increment frame_cnt, then go to ARMED on the next cycle.
REQ-026 SHALL ignore pix_valid when href_in=0 and in any state other than CAPTURE.
REQ-027 SHALL, when a kept byte's write and an href_in falling edge fall in the same cycle, write the byte at the pre-update address.

Reset
REQ-028 SHALL, while rst_n=0, force state=IDLE, row=col=phase=0, and all outputs 0 (including frame_ready, frame_cnt and error flags), independent of clk.
REQ-029 SHALL, on a mid-frame reset, discard the partial frame, with no frame_done and no further writes until a full ARMED->CAPTURE sequence.

Configuration
REQ-030 SHALL, with FRAME_CAPTURE_ERR_EN defined, set line_err (sticky) when href_in falls in CAPTURE with col!=H_ACTIVE, and set frame_err (sticky) when CAPTURE ends with row!=V_ACTIVE; err_clr=1 SHALL clear both, with a set in the same cycle taking priority.
REQ-031 SHALL, without FRAME_CAPTURE_ERR_EN, keep all three ports, tie line_err=frame_err=0, and ignore err_clr.

Structure
REQ-032 SHALL place the state enum and the default H_ACTIVE, V_ACTIVE and ADDR_W constants in the shared package frame_pkg.
REQ-033 SHALL contain one natural sub-module, sync_edge_det, for registered rise/fall detection; it SHALL be instantiated for vsync_in and href_in.

Verification
REQ-034 SHALL cover: a full 640x480 frame with 1280 bytes per line -> 307200 writes, last bram_addr=307199, frame_done one pulse, frame_cnt=1, frame_ready=1.
REQ-035 SHALL cover: a line with 1282 bytes -> exactly 640 writes, no write to addr 640 from row 0, line_err=1 only when the macro is defined.
REQ-036 SHALL cover: capture_en=0 during a vsync_in fall -> zero writes that frame and frame_cnt unchanged; re-enabling before the next fall -> capture resumes.
REQ-037 SHALL cover: rst_n pulsed low at row 100 -> outputs 0 immediately, no frame_done, and the next frame starts at addr 0.
REQ-038 SHALL cover: 256 frames -> frame_cnt wraps to 0 while frame_ready stays 1.
REQ-039 SHALL cover: a frame of only 479 lines -> frame_done still pulses, and frame_err=1 with the macro (0 without); err_clr then clears it.
